// File: rtl/tlul_sram_adapter_if.sv
// TL-UL A/D channel bundle between a host and the SRAM adapter.
// The host drives the A channel plus d_ready; the device drives the D channel plus a_ready.
interface tlul_sram_adapter_if;
  logic        a_valid;
  logic [2:0]  a_opcode;
  logic [2:0]  a_param;
  logic [1:0]  a_size;
  logic [7:0]  a_source;
  logic [31:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic        d_ready;

  logic        d_valid;
  logic [2:0]  d_opcode;
  logic [2:0]  d_param;
  logic [1:0]  d_size;
  logic [7:0]  d_source;
  logic        d_sink;
  logic [31:0] d_data;
  logic        d_user;
  logic        d_error;
  logic        a_ready;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
    input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_user, d_error, a_ready
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
    output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_user, d_error, a_ready
  );
endinterface

// File: rtl/tlul_sram_adapter.sv
// TL-UL device adapter onto a req/gnt/rvalid single-port SRAM, in-order responses.
// Define TLUL_SRAM_ERR_CHK_EN to also reject bad size/alignment/mask requests locally.
module tlul_sram_adapter #(
  parameter int unsigned SramAw      = 12,
  parameter int unsigned Outstanding = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  tlul_sram_adapter_if.slave tl,
  output logic               req_o,
  input  logic               gnt_i,
  output logic               we_o,
  output logic [SramAw-1:0]  addr_o,
  output logic [31:0]        wdata_o,
  output logic [31:0]        wmask_o,
  input  logic [31:0]        rdata_i,
  input  logic               rvalid_i
);

  localparam logic [2:0] OpPutFull    = 3'd0;
  localparam logic [2:0] OpPutPartial = 3'd1;
  localparam logic [2:0] OpGet        = 3'd4;
  localparam logic [2:0] OpAck        = 3'd0;
  localparam logic [2:0] OpAckData    = 3'd1;

  localparam int unsigned PtrW = (Outstanding > 1) ? $clog2(Outstanding) : 1;
  localparam int unsigned CntW = $clog2(Outstanding + 1);

  typedef struct packed {
    logic       is_read;
    logic       error;
    logic [1:0] size;
    logic [7:0] source;
  } req_t;

  function automatic logic [PtrW-1:0] f_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Outstanding - 1)) ? '0 : p + 1'b1;
  endfunction

  logic w_chk_err;
  logic w_error;

`ifdef TLUL_SRAM_ERR_CHK_EN
  logic [3:0] w_lane;
  logic       w_unused;

  always_comb begin
    w_lane    = '0;
    w_chk_err = 1'b0;
    case (tl.a_size)
      2'd0: w_lane = 4'b0001 << tl.a_address[1:0];
      2'd1: begin
        w_lane    = tl.a_address[1] ? 4'b1100 : 4'b0011;
        w_chk_err = tl.a_address[0];
      end
      2'd2: begin
        w_lane    = 4'b1111;
        w_chk_err = |tl.a_address[1:0];
      end
      default: w_chk_err = 1'b1;
    endcase
    if ((tl.a_mask & ~w_lane) != '0) w_chk_err = 1'b1;
    if ((tl.a_opcode == OpPutFull) && ((tl.a_mask & w_lane) != w_lane)) w_chk_err = 1'b1;
  end

  assign w_unused = ^{tl.a_param, tl.a_address[31:SramAw+2]};
`else
  logic w_unused;

  assign w_chk_err = 1'b0;
  assign w_unused  = ^{tl.a_param, tl.a_address[31:SramAw+2], tl.a_address[1:0]};
`endif

  assign w_error = !(tl.a_opcode inside {OpGet, OpPutFull, OpPutPartial}) | w_chk_err;

  req_t                r_rq_mem [Outstanding];
  logic [PtrW-1:0]     r_rq_wptr, r_rq_rptr;
  logic [CntW-1:0]     r_rq_cnt;
  logic [31:0]         r_rs_mem [Outstanding];
  logic [PtrW-1:0]     r_rs_wptr, r_rs_rptr;
  logic [CntW-1:0]     r_rs_cnt;

  logic w_rq_full, w_rq_empty, w_rs_empty;
  logic w_a_ready, w_accept;
  logic w_head_valid, w_d_fire, w_rs_pop;
  req_t w_head, w_new;

  assign w_rq_full  = (r_rq_cnt == CntW'(Outstanding));
  assign w_rq_empty = (r_rq_cnt == '0);
  assign w_rs_empty = (r_rs_cnt == '0);

  assign w_a_ready = !w_rq_full & (w_error | gnt_i);
  assign w_accept  = tl.a_valid & w_a_ready;

  assign w_new.is_read = (tl.a_opcode == OpGet);
  assign w_new.error   = w_error;
  assign w_new.size    = tl.a_size;
  assign w_new.source  = tl.a_source;

  assign w_head       = r_rq_mem[r_rq_rptr];
  assign w_head_valid = !w_rq_empty & (w_head.error | !w_rs_empty);
  assign w_d_fire     = w_head_valid & tl.d_ready;
  assign w_rs_pop     = w_d_fire & !w_head.error;

  assign req_o   = tl.a_valid & !w_error & !w_rq_full;
  assign we_o    = (tl.a_opcode != OpGet);
  assign addr_o  = tl.a_address[SramAw+1:2];
  assign wdata_o = tl.a_data;

  always_comb begin
    wmask_o = '0;
    for (int unsigned b = 0; b < 4; b++) wmask_o[8*b +: 8] = {8{tl.a_mask[b]}};
  end

  always_ff @(posedge clk_i) begin
    if (w_accept) r_rq_mem[r_rq_wptr] <= w_new;
    if (rvalid_i) r_rs_mem[r_rs_wptr] <= rdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rq_wptr <= '0;
      r_rq_rptr <= '0;
      r_rq_cnt  <= '0;
      r_rs_wptr <= '0;
      r_rs_rptr <= '0;
      r_rs_cnt  <= '0;
    end else begin
      if (w_accept) r_rq_wptr <= f_inc(r_rq_wptr);
      if (w_d_fire) r_rq_rptr <= f_inc(r_rq_rptr);
      unique case ({w_accept, w_d_fire})
        2'b10:   r_rq_cnt <= r_rq_cnt + 1'b1;
        2'b01:   r_rq_cnt <= r_rq_cnt - 1'b1;
        default: ;
      endcase
      if (rvalid_i) r_rs_wptr <= f_inc(r_rs_wptr);
      if (w_rs_pop) r_rs_rptr <= f_inc(r_rs_rptr);
      unique case ({rvalid_i, w_rs_pop})
        2'b10:   r_rs_cnt <= r_rs_cnt + 1'b1;
        2'b01:   r_rs_cnt <= r_rs_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // D channel is decoded from FIFO state only, so it is held stable until d_ready
  // and reaches d_valid one cycle earlier than a separate output register would.
  assign tl.a_ready  = w_a_ready;
  assign tl.d_valid  = w_head_valid;
  assign tl.d_opcode = (w_head_valid && w_head.is_read) ? OpAckData : OpAck;
  assign tl.d_size   = w_head_valid ? w_head.size : '0;
  assign tl.d_source = w_head_valid ? w_head.source : '0;
  assign tl.d_error  = w_head_valid & w_head.error;
  assign tl.d_data   = (w_head_valid && w_head.is_read && !w_head.error) ? r_rs_mem[r_rs_rptr] : '0;
  assign tl.d_param  = '0;
  assign tl.d_sink   = 1'b0;
  assign tl.d_user   = 1'b0;

endmodule

// File: tb/tb_tlul_sram_adapter.sv
// Scoreboard bench for tlul_sram_adapter: directed TL-UL requests against a one-cycle SRAM model.
module tb_tlul_sram_adapter;
  localparam int unsigned SramAw = 12;

  typedef struct packed {
    logic [2:0]  op;
    logic [1:0]  size;
    logic [7:0]  src;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req, gnt, we, rvalid;
  logic [SramAw-1:0] addr;
  logic [31:0]       wdata, wmask, rdata;

  int   n_cmp = 0;
  int   n_mis = 0;
  rsp_t sb[$];
  rsp_t mon_exp, mon_act;

  tlul_sram_adapter_if tl_bus ();

  tlul_sram_adapter #(.SramAw(SramAw), .Outstanding(2)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .tl       (tl_bus),
    .req_o    (req),
    .gnt_i    (gnt),
    .we_o     (we),
    .addr_o   (addr),
    .wdata_o  (wdata),
    .wmask_o  (wmask),
    .rdata_i  (rdata),
    .rvalid_i (rvalid)
  );

  always #5 clk = ~clk;

  // SRAM model: rvalid one cycle after grant; preloaded words restored on reset
  logic [31:0] mem [0:(1<<SramAw)-1];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid  <= 1'b0;
      rdata   <= '0;
      mem[0]  <= 32'h01234567;
      mem[4]  <= 32'hDEADBEEF;
      mem[8]  <= 32'hAAAAAAAA;
      mem[12] <= 32'h11111111;
      mem[16] <= 32'h55AA55AA;
      mem[17] <= 32'h0BADF00D;
      mem[20] <= 32'hA0000001;
      mem[21] <= 32'hA0000002;
      mem[22] <= 32'hA0000003;
    end else begin
      rvalid <= req & gnt;
      if (req & gnt) begin
        if (we) mem[addr] <= (mem[addr] & ~wmask) | (wdata & wmask);
        else    rdata     <= mem[addr];
      end
    end
  end

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endfunction

  function automatic rsp_t mk(input logic [2:0] op, input logic [1:0] sz, input logic [7:0] src,
                              input logic [31:0] data, input logic err);
    rsp_t r;
    r.op = op; r.size = sz; r.src = src; r.data = data; r.err = err;
    return r;
  endfunction

  // Monitor: compare every consumed D beat against the scoreboard head
  always @(negedge clk) begin
    if (rst_n && tl_bus.d_valid && tl_bus.d_ready) begin
      mon_act = mk(tl_bus.d_opcode, tl_bus.d_size, tl_bus.d_source, tl_bus.d_data, tl_bus.d_error);
      if (sb.size() == 0) begin
        n_cmp++;
        n_mis++;
        $display("FAIL d_unexpected: got rsp 0x%0h required none", mon_act);
      end else begin
        mon_exp = sb.pop_front();
        check("d_rsp", 64'(mon_act), 64'(mon_exp));
        check("d_zero_fields", 64'({tl_bus.d_param, tl_bus.d_sink, tl_bus.d_user}), 64'(0));
      end
    end
  end

  task automatic drive_a(input logic [2:0] op, input logic [31:0] adr, input logic [1:0] sz,
                         input logic [3:0] msk, input logic [31:0] dat, input logic [7:0] src);
    tl_bus.a_valid   = 1'b1;
    tl_bus.a_opcode  = op;
    tl_bus.a_address = adr;
    tl_bus.a_size    = sz;
    tl_bus.a_mask    = msk;
    tl_bus.a_data    = dat;
    tl_bus.a_source  = src;
  endtask

  task automatic wait_accept(input rsp_t exp, input logic exp_we, input logic [SramAw-1:0] exp_addr,
                             input logic [31:0] exp_wmask, output int waited);
    bit got;
    got    = 1'b0;
    waited = 0;
    while (!got && waited < 50) begin
      @(negedge clk);
      waited++;
      if (tl_bus.a_valid && tl_bus.a_ready) got = 1'b1;
    end
    if (got) begin
      sb.push_back(exp);
      check("req_o", 64'(req), 64'(!exp.err));
      if (!exp.err) begin
        check("we_o", 64'(we), 64'(exp_we));
        check("addr_o", 64'(addr), 64'(exp_addr));
        check("wmask_o", 64'(wmask), 64'(exp_wmask));
      end
    end else begin
      n_cmp++;
      n_mis++;
      $display("FAIL accept_timeout: a_ready low for %0d cycles, required 1", waited);
    end
    @(posedge clk);
    #1 tl_bus.a_valid = 1'b0;
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] adr, input logic [1:0] sz,
                      input logic [3:0] msk, input logic [31:0] dat, input logic [7:0] src,
                      input logic exp_err, input logic [31:0] exp_data,
                      input logic [SramAw-1:0] exp_addr, input logic [31:0] exp_wmask);
    int w;
    drive_a(op, adr, sz, msk, dat, src);
    wait_accept(mk((op == 3'd4) ? 3'd1 : 3'd0, sz, src, exp_data, exp_err),
                (op != 3'd4), exp_addr, exp_wmask, w);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int w;
    rst_n = 1'b0;
    gnt   = 1'b1;
    tl_bus.a_valid   = 1'b0;
    tl_bus.a_opcode  = 3'd4;
    tl_bus.a_param   = 3'd0;
    tl_bus.a_size    = 2'd2;
    tl_bus.a_source  = 8'd0;
    tl_bus.a_address = '0;
    tl_bus.a_mask    = 4'hF;
    tl_bus.a_data    = '0;
    tl_bus.d_ready   = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_d_valid", 64'(tl_bus.d_valid), 64'(0));
    check("rst_req_o", 64'(req), 64'(0));
    check("rst_d_data", 64'(tl_bus.d_data), 64'(0));
    check("rst_d_source", 64'(tl_bus.d_source), 64'(0));
    check("rst_d_opcode", 64'(tl_bus.d_opcode), 64'(0));
    check("rst_d_error", 64'(tl_bus.d_error), 64'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Get 0x10: d_valid two cycles after grant
    send(3'd4, 32'h10, 2'd2, 4'hF, 32'h0, 8'd3, 1'b0, 32'hDEADBEEF, 12'h004, 32'hFFFFFFFF);
    @(negedge clk);
    check("get_lat_n1", 64'(tl_bus.d_valid), 64'(0));
    @(negedge clk);
    check("get_lat_n2", 64'(tl_bus.d_valid), 64'(1));
    drain();

    // Grant withheld: request visible, not accepted
    gnt = 1'b0;
    drive_a(3'd4, 32'h44, 2'd2, 4'hF, 32'h0, 8'd5);
    @(negedge clk);
    check("stall_a_ready", 64'(tl_bus.a_ready), 64'(0));
    check("stall_req_o", 64'(req), 64'(1));
    @(posedge clk);
    #1 gnt = 1'b1;
    wait_accept(mk(3'd1, 2'd2, 8'd5, 32'h0BADF00D, 1'b0), 1'b0, 12'h011, 32'hFFFFFFFF, w);
    drain();

    // PutPartialData low halfword, then read back merged word
    send(3'd1, 32'h20, 2'd1, 4'h3, 32'h00001234, 8'd1, 1'b0, 32'h0, 12'h008, 32'h0000FFFF);
    send(3'd4, 32'h20, 2'd2, 4'hF, 32'h0, 8'd2, 1'b0, 32'hAAAA1234, 12'h008, 32'hFFFFFFFF);
    drain();

    // Full with d_ready low; third Get waits, pop cycle still not ready
    tl_bus.d_ready = 1'b0;
    send(3'd4, 32'h50, 2'd2, 4'hF, 32'h0, 8'd10, 1'b0, 32'hA0000001, 12'h014, 32'hFFFFFFFF);
    send(3'd4, 32'h54, 2'd2, 4'hF, 32'h0, 8'd11, 1'b0, 32'hA0000002, 12'h015, 32'hFFFFFFFF);
    drive_a(3'd4, 32'h58, 2'd2, 4'hF, 32'h0, 8'd12);
    @(negedge clk);
    check("full_a_ready", 64'(tl_bus.a_ready), 64'(0));
    check("full_req_o", 64'(req), 64'(0));
    @(negedge clk);
    check("full_a_ready_hold", 64'(tl_bus.a_ready), 64'(0));
    @(posedge clk);
    #1 tl_bus.d_ready = 1'b1;
    wait_accept(mk(3'd1, 2'd2, 8'd12, 32'hA0000003, 1'b0), 1'b0, 12'h016, 32'hFFFFFFFF, w);
    check("full_pop_accept_wait", 64'(w), 64'(2));
    drain();

    // Illegal opcode behind a pending Get, accepted without grant
    tl_bus.d_ready = 1'b0;
    send(3'd4, 32'h0, 2'd2, 4'hF, 32'h0, 8'd4, 1'b0, 32'h01234567, 12'h000, 32'hFFFFFFFF);
    gnt = 1'b0;
    send(3'd3, 32'h0, 2'd2, 4'hF, 32'h0, 8'd6, 1'b1, 32'h0, 12'h000, 32'hFFFFFFFF);
    gnt = 1'b1;
    repeat (3) @(negedge clk);
    check("hol_d_error", 64'(tl_bus.d_error), 64'(0));
    check("hol_d_source", 64'(tl_bus.d_source), 64'(4));
    @(posedge clk);
    #1 tl_bus.d_ready = 1'b1;
    drain();

    // Isolated error: d_valid one cycle after accept
    send(3'd7, 32'h0, 2'd2, 4'hF, 32'h0, 8'd7, 1'b1, 32'h0, 12'h000, 32'hFFFFFFFF);
    @(negedge clk);
    check("err_lat_n1", 64'(tl_bus.d_valid), 64'(1));
    drain();

    // Reset with two Gets in flight
    tl_bus.d_ready = 1'b0;
    send(3'd4, 32'h40, 2'd2, 4'hF, 32'h0, 8'd8, 1'b0, 32'h55AA55AA, 12'h010, 32'hFFFFFFFF);
    send(3'd4, 32'h44, 2'd2, 4'hF, 32'h0, 8'd9, 1'b0, 32'h0BADF00D, 12'h011, 32'hFFFFFFFF);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_d_valid", 64'(tl_bus.d_valid), 64'(0));
    check("rst_mid_d_source", 64'(tl_bus.d_source), 64'(0));
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tl_bus.d_ready = 1'b1;
    send(3'd4, 32'h44, 2'd2, 4'hF, 32'h0, 8'd9, 1'b0, 32'h0BADF00D, 12'h011, 32'hFFFFFFFF);
    drain();

    // PutFullData with partial mask
`ifdef TLUL_SRAM_ERR_CHK_EN
    send(3'd0, 32'h30, 2'd2, 4'h7, 32'hCAFEBABE, 8'd13, 1'b1, 32'h0, 12'h00C, 32'h00FFFFFF);
    send(3'd4, 32'h30, 2'd2, 4'hF, 32'h0, 8'd14, 1'b0, 32'h11111111, 12'h00C, 32'hFFFFFFFF);
`else
    send(3'd0, 32'h30, 2'd2, 4'h7, 32'hCAFEBABE, 8'd13, 1'b0, 32'h0, 12'h00C, 32'h00FFFFFF);
    send(3'd4, 32'h30, 2'd2, 4'hF, 32'h0, 8'd14, 1'b0, 32'h11FEBABE, 12'h00C, 32'hFFFFFFFF);
`endif
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
